// File: rtl/cbf_spectrum_byte_serializer_pkg.sv
// rtl/cbf_spectrum_byte_serializer_pkg.sv - state encoding, sync default and sizing helper for the spectrum byte serializer
// CBF_SERIALIZER_CHECKSUM_EN adds the CSUM state.
package cbf_spectrum_byte_serializer_pkg;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    SEQ,
    DATA,
    WAIT
`ifdef CBF_SERIALIZER_CHECKSUM_EN
    ,
    CSUM
`endif
  } state_t;

  function automatic int bytes_per_word(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/cbf_spectrum_byte_serializer_if.sv
// rtl/cbf_spectrum_byte_serializer_if.sv - stream handshake bundle used for both the word input and the byte output
interface cbf_spectrum_byte_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/cbf_spectrum_byte_serializer.sv
// rtl/cbf_spectrum_byte_serializer.sv - packs one power spectrum frame into a SYNC/SEQ-framed 8-bit stream
// CBF_SERIALIZER_CHECKSUM_EN appends a mod-256 checksum byte after the payload.
module cbf_spectrum_byte_serializer
  import cbf_spectrum_byte_serializer_pkg::*;
#(
  parameter int          WORD_LENGTH_IN = 88,
  parameter int          NUM_BINS       = 51,
  parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  cbf_spectrum_byte_serializer_if.slave         s_axis,
  cbf_spectrum_byte_serializer_if.master        m_axis,
  output logic                                  frame_err
);

  localparam int BYTES_PER_WORD = bytes_per_word(WORD_LENGTH_IN);
  localparam int HOLD_W         = BYTES_PER_WORD * 8;
  localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int CNT_W          = $clog2(NUM_BINS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_BINS);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [7:0]        seq_q, seq_d;
`ifdef CBF_SERIALIZER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              xfer;
  logic              accept;
  logic              final_byte;
  logic [CNT_W-1:0]  cnt_next;
  logic [HOLD_W-1:0] hold_shift;
  logic [7:0]        payload_byte;

  assign xfer         = m_axis.tvalid && m_axis.tready;
  assign accept       = s_axis.tvalid && s_axis.tready;
  assign final_byte   = (state_q == DATA) && (idx_q == IDX_LAST);
  assign cnt_next     = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
  assign hold_shift   = hold_q << {idx_q, 3'b000};
  assign payload_byte = hold_shift[HOLD_W-1 -: 8];
  assign frame_err    = final_byte && last_q && err_q && xfer;

  // Outputs decode straight from the state register, so reset clears them asynchronously.
  always_comb begin
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = 8'h00;
    m_axis.tlast  = 1'b0;
    s_axis.tready = 1'b0;
    case (state_q)
      IDLE, WAIT: s_axis.tready = 1'b1;
      HDR0: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = SYNC_WORD[15:8];
      end
      HDR1: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = SYNC_WORD[7:0];
      end
      SEQ: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = seq_q;
      end
      DATA: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = payload_byte;
`ifndef CBF_SERIALIZER_CHECKSUM_EN
        m_axis.tlast  = final_byte && last_q;
`endif
        s_axis.tready = final_byte && !last_q && m_axis.tready;
      end
`ifdef CBF_SERIALIZER_CHECKSUM_EN
      CSUM: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = csum_q;
        m_axis.tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    seq_d   = seq_q;
`ifdef CBF_SERIALIZER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    // A word is last on input tlast or on reaching NUM_BINS; a mismatch between the two is a framing error.
    if (accept) begin
      hold_d  = HOLD_W'(s_axis.tdata);
      idx_d   = '0;
      cnt_d   = cnt_next;
      last_d  = s_axis.tlast || (cnt_next == CNT_MAX);
      err_d   = s_axis.tlast != (cnt_next == CNT_MAX);
      state_d = (state_q == IDLE) ? HDR0 : DATA;
    end
    case (state_q)
      IDLE: begin
`ifdef CBF_SERIALIZER_CHECKSUM_EN
        csum_d = 8'h00;
`endif
      end
      HDR0: if (xfer) state_d = HDR1;
      HDR1: if (xfer) state_d = SEQ;
      SEQ: if (xfer) begin
        state_d = DATA;
`ifdef CBF_SERIALIZER_CHECKSUM_EN
        csum_d  = csum_q + seq_q;
`endif
      end
      DATA: if (xfer) begin
`ifdef CBF_SERIALIZER_CHECKSUM_EN
        csum_d = csum_q + payload_byte;
`endif
        if (!final_byte) begin
          idx_d = idx_q + 1'b1;
        end else if (last_q) begin
`ifdef CBF_SERIALIZER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = IDLE;
          seq_d   = seq_q + 1'b1;
`endif
        end else if (!accept) begin
          state_d = WAIT;
        end
      end
`ifdef CBF_SERIALIZER_CHECKSUM_EN
      CSUM: if (xfer) begin
        state_d = IDLE;
        seq_d   = seq_q + 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      seq_q   <= 8'h00;
`ifdef CBF_SERIALIZER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      seq_q   <= seq_d;
`ifdef CBF_SERIALIZER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_cbf_spectrum_byte_serializer.sv
// tb/tb_cbf_spectrum_byte_serializer.sv - directed self-checking bench for the spectrum byte serializer
module tb_cbf_spectrum_byte_serializer;

  localparam int W   = 88;
  localparam int NB  = 51;
  localparam int BPW = 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic frame_err;

  always #5 clk = ~clk;

  cbf_spectrum_byte_serializer_if #(.WIDTH(W)) s_if ();
  cbf_spectrum_byte_serializer_if #(.WIDTH(8)) m_if ();

  cbf_spectrum_byte_serializer #(
    .WORD_LENGTH_IN(W),
    .NUM_BINS(NB),
    .SYNC_WORD(16'hA55A)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis(s_if),
    .m_axis(m_if),
    .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_data[$];
  logic         src_last[$];
  logic [7:0]   rx_data[$];
  logic         rx_last[$];
  int           rx_err[$];
  logic [7:0]   exp_data[$];
  logic         exp_last[$];
  int           exp_err[$];

  logic       acc_pend = 1'b0;
  logic       stalled  = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input int k, input logic last);
    logic [7:0] b;
    b = k[7:0];
    src_data.push_back({BPW{b}});
    src_last.push_back(last);
  endtask

  task automatic add_frame(input int seq, input int k0, input int n, input logic err);
    exp_data.push_back(8'hA5); exp_last.push_back(1'b0);
    exp_data.push_back(8'h5A); exp_last.push_back(1'b0);
    exp_data.push_back(8'(seq)); exp_last.push_back(1'b0);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < BPW; b++) begin
        exp_data.push_back(8'(k0 + w));
        exp_last.push_back((w == n - 1) && (b == BPW - 1));
      end
    end
    if (err) exp_err.push_back(exp_data.size() - 1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, rx_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < rx_data.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_data[i], exp_data[i]);
      check($sformatf("%s_tlast%0d", tag, i), rx_last[i], exp_last[i]);
    end
    check({tag, "_err_count"}, rx_err.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < rx_err.size(); i++)
      check($sformatf("%s_err_pos%0d", tag, i), rx_err[i], exp_err[i]);
    rx_data.delete(); rx_last.delete(); rx_err.delete();
    exp_data.delete(); exp_last.delete(); exp_err.delete();
  endtask

  // One loop iteration per clock: drive at negedge, sample 1 ns later, commit at posedge.
  task automatic run(input logic rnd, input int stop_bytes, input int budget);
    int   idle = 0;
    int   cyc  = 0;
    logic done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      if (acc_pend) begin
        s_if.tvalid = 1'b0;
        acc_pend    = 1'b0;
      end
      m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!s_if.tvalid && src_data.size() > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = src_data[0];
        s_if.tlast  = src_last[0];
      end
      #1;
      if (stalled) begin
        check("stall_tvalid", m_if.tvalid, 1'b1);
        check("stall_tdata", m_if.tdata, prev_data);
        check("stall_tlast", m_if.tlast, prev_last);
      end
      if (m_if.tvalid && m_if.tready) begin
        rx_data.push_back(m_if.tdata);
        rx_last.push_back(m_if.tlast);
        if (frame_err) rx_err.push_back(rx_data.size() - 1);
      end else if (frame_err) begin
        rx_err.push_back(-1);
      end
      if (s_if.tvalid && s_if.tready) begin
        void'(src_data.pop_front());
        void'(src_last.pop_front());
        acc_pend = 1'b1;
      end
      stalled   = m_if.tvalid && !m_if.tready;
      prev_data = m_if.tdata;
      prev_last = m_if.tlast;
      idle = (src_data.size() == 0 && !s_if.tvalid && !m_if.tvalid) ? idle + 1 : 0;
      cyc++;
      if (idle >= 2 || (stop_bytes > 0 && rx_data.size() == stop_bytes)) done = 1'b1;
    end
    check("run_done", done, 1'b1);
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tvalid", m_if.tvalid, 1'b0);
    check("rst_tdata", m_if.tdata, 8'h00);
    check("rst_tlast", m_if.tlast, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_s_tready", s_if.tready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame, continuous flow
    for (int k = 0; k < NB; k++) push_word(k, k == NB - 1);
    run(1'b0, 0, 2000);
    add_frame(0, 0, NB, 1'b0);
    compare("full");

    // Same frame under random output stalls and input gaps
    for (int k = 0; k < NB; k++) push_word(k, k == NB - 1);
    run(1'b1, 0, 6000);
    add_frame(1, 0, NB, 1'b0);
    compare("rand");

    // Early tlast on word 3, with a WAIT gap after word 1
    push_word(0, 1'b0);
    run(1'b0, 0, 200);
    check("wait_tvalid", m_if.tvalid, 1'b0);
    check("wait_s_tready", s_if.tready, 1'b1);
    push_word(1, 1'b0);
    push_word(2, 1'b1);
    run(1'b0, 0, 200);
    add_frame(2, 0, 3, 1'b1);
    compare("short");

    // Missing tlast: forced close after 51 words, overflow words open the next frame
    for (int k = 0; k < NB + 2; k++) push_word(k, 1'b0);
    run(1'b0, 0, 2000);
    check("open_tvalid", m_if.tvalid, 1'b0);
    push_word(NB + 2, 1'b1);
    run(1'b0, 0, 200);
    add_frame(3, 0, NB, 1'b1);
    add_frame(4, NB, 3, 1'b1);
    compare("long");

    // Reset in the middle of bin 10
    for (int k = 0; k < NB; k++) push_word(k, k == NB - 1);
    run(1'b0, 3 + 10 * BPW + 6, 2000);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_if.tvalid, 1'b0);
    check("midrst_tdata", m_if.tdata, 8'h00);
    check("midrst_tlast", m_if.tlast, 1'b0);
    check("midrst_s_tready", s_if.tready, 1'b1);
    s_if.tvalid = 1'b0;
    src_data.delete(); src_last.delete();
    rx_data.delete(); rx_last.delete(); rx_err.delete();
    acc_pend = 1'b0;
    stalled  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 257 one-word frames: SEQ runs 00..FF then wraps to 00
    for (int i = 0; i < 257; i++) push_word(i, 1'b1);
    run(1'b0, 0, 8000);
    for (int i = 0; i < 257; i++) add_frame(i % 256, i, 1, 1'b1);
    compare("seqwrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
